// File: rtl/mem_write_port_pkg.sv
// ---------------------------------------------------------------------------
// mem_write_port_pkg
//  Shared definitions for the write-back memory port:
//   - byte-count codes carried with each request (ONE/TWO/THREE = 0/1/2;
//     code 3 is reserved and behaves like ONE)
//   - serializer FSM state encodings (IDLE/WRITE)
//   - FIFO entry width for the default 16-bit address: 2 + 16 + 24 = 42
//   - byte-selection helpers that fix the descending 6502 push order
// ---------------------------------------------------------------------------
package mem_write_port_pkg;

    localparam int ENTRY_W = 42;

    typedef enum logic [1:0] {
        CNT_ONE   = 2'd0,
        CNT_TWO   = 2'd1,
        CNT_THREE = 2'd2,
        CNT_RSVD  = 2'd3
    } cnt_e;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_WRITE = 1'b1
    } state_e;

    // Reserved count code collapses to a single-byte request.
    function automatic logic [1:0] norm_cnt(input logic [1:0] cnt);
        logic [1:0] res;
        if (cnt == CNT_RSVD) begin
            res = CNT_ONE;
        end else begin
            res = cnt;
        end
        return res;
    endfunction

    // First byte of a request: a lone byte is the low byte, otherwise the
    // high byte goes first (descending push order).
    function automatic logic [7:0] first_byte(input logic [23:0] dat, input logic [1:0] cnt);
        logic [7:0] res;
        case (cnt)
            CNT_TWO, CNT_THREE: res = dat[15:8];
            default:            res = dat[7:0];
        endcase
        return res;
    endfunction

    // Subsequent bytes of a multi-byte request: lo, then P.
    function automatic logic [7:0] next_byte(input logic [23:0] dat, input logic [1:0] idx);
        logic [7:0] res;
        case (idx)
            2'd1:    res = dat[7:0];
            2'd2:    res = dat[23:16];
            default: res = dat[7:0];
        endcase
        return res;
    endfunction

endpackage

// File: rtl/mem_write_port_fifo.sv
// ---------------------------------------------------------------------------
// mem_wr_fifo
//  Synchronous FIFO with registered storage and a combinational head.
//  Push while full and pop while empty are ignored.
//  Ports:
//   clk_i, rst_n_i   clock / asynchronous active-low reset
//   push_i, data_i   write an entry at the tail
//   pop_i            remove the head entry
//   data_o           current head entry (valid when !empty_o)
//   full_o, empty_o  occupancy flags
//   count_o          number of stored entries
// ---------------------------------------------------------------------------
module mem_wr_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 42,
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CW-1:0]    count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_q, rd_q;
    logic [CW-1:0]    count_q;
    logic             do_push_s, do_pop_s;

    assign full_o    = (count_q == CW'(DEPTH));
    assign empty_o   = (count_q == {CW{1'b0}});
    assign count_o   = count_q;
    assign data_o    = mem_q[rd_q];
    assign do_push_s = push_i & ~full_o;
    assign do_pop_s  = pop_i & ~empty_o;

    // Storage array and tail pointer; pointers wrap explicitly so any depth works.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {WIDTH{1'b0}};
            end
            wr_q <= {PW{1'b0}};
        end else if (do_push_s) begin
            mem_q[wr_q] <= data_i;
            wr_q        <= (wr_q == PW'(DEPTH - 1)) ? {PW{1'b0}} : wr_q + PW'(1);
        end else begin
            wr_q <= wr_q;
        end
    end

    // Head pointer.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rd_q <= {PW{1'b0}};
        end else if (do_pop_s) begin
            rd_q <= (rd_q == PW'(DEPTH - 1)) ? {PW{1'b0}} : rd_q + PW'(1);
        end else begin
            rd_q <= rd_q;
        end
    end

    // Occupancy count; simultaneous push and pop leave it unchanged.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            count_q <= {CW{1'b0}};
        end else if (do_push_s && !do_pop_s) begin
            count_q <= count_q + CW'(1);
        end else if (!do_push_s && do_pop_s) begin
            count_q <= count_q - CW'(1);
        end else begin
            count_q <= count_q;
        end
    end

endmodule

// File: rtl/mem_write_port.sv
// ---------------------------------------------------------------------------
// mem_write_port
//  Accepts 1-3 byte write requests from the write-back stage, queues them in
//  a small FIFO and serializes them onto a byte-wide RAM port using a
//  valid/ready handshake. Bytes go out in descending address order; the
//  address decrement wraps inside the 256-byte page.
//  Optional build macro: MEM_WR_OVF_EN adds the sticky ovf_o output, set
//  when a request arrives while the FIFO is full.
//  Ports:
//   clk_i, rst_n_i  clock / asynchronous active-low reset
//   mem_w_enb_i     request valid (one cycle per request)
//   mem_w_cnt_i     byte-count code (0/1/2 = 1/2/3 bytes, 3 = 1 byte)
//   mem_w_adr_i     address of the first (highest) byte
//   mem_w_dat_i     {P, hi, lo}
//   mem_stl_o       stall to the pipeline (count >= FIFO_DEPTH-1)
//   ram_we_o        byte write valid (registered)
//   ram_adr_o       byte address (registered)
//   ram_dat_o       byte data (registered)
//   ram_rdy_i       RAM accepts the byte when ram_we_o && ram_rdy_i
//   idle_o          FIFO empty and serializer idle
//   ovf_o           sticky overflow flag (MEM_WR_OVF_EN only)
// ---------------------------------------------------------------------------
module mem_write_port
    import mem_write_port_pkg::*;
#(
    parameter int FIFO_DEPTH = 2,   // legal 2..8
    parameter int AW         = 16
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          mem_w_enb_i,
    input  logic [1:0]    mem_w_cnt_i,
    input  logic [AW-1:0] mem_w_adr_i,
    input  logic [23:0]   mem_w_dat_i,
    output logic          mem_stl_o,
    output logic          ram_we_o,
    output logic [AW-1:0] ram_adr_o,
    output logic [7:0]    ram_dat_o,
    input  logic          ram_rdy_i,
    output logic          idle_o
`ifdef MEM_WR_OVF_EN
    ,
    output logic          ovf_o
`endif
);

    localparam int EW = ENTRY_W - 16 + AW;
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    // FIFO interface
    logic [EW-1:0] head_s;
    logic [1:0]    head_cnt_s;
    logic [AW-1:0] head_adr_s;
    logic [23:0]   head_dat_s;
    logic          full_s, empty_s, pop_s;
    logic [CW-1:0] count_s;

    // Serializer state
    state_e        state_q, state_d;
    logic [AW-1:0] cur_adr_q, cur_adr_d;
    logic [23:0]   cur_dat_q, cur_dat_d;
    logic [1:0]    rem_q, rem_d;
    logic [1:0]    idx_q, idx_d;
    logic          ram_we_q, ram_we_d;
    logic [AW-1:0] ram_adr_q, ram_adr_d;
    logic [7:0]    ram_dat_q, ram_dat_d;
    logic          accept_s, last_s;

    mem_wr_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (EW)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .push_i  (mem_w_enb_i),
        .data_i  ({mem_w_cnt_i, mem_w_adr_i, mem_w_dat_i}),
        .pop_i   (pop_s),
        .data_o  (head_s),
        .full_o  (full_s),
        .empty_o (empty_s),
        .count_o (count_s)
    );

    assign head_cnt_s = norm_cnt(head_s[EW-1:EW-2]);
    assign head_adr_s = head_s[AW+23:24];
    assign head_dat_s = head_s[23:0];

    assign accept_s  = ram_we_q & ram_rdy_i;
    assign last_s    = (rem_q == 2'd0);
    assign mem_stl_o = (count_s >= CW'(FIFO_DEPTH - 1));
    assign idle_o    = empty_s & (state_q == ST_IDLE);
    assign ram_we_o  = ram_we_q;
    assign ram_adr_o = ram_adr_q;
    assign ram_dat_o = ram_dat_q;

    // FSM state register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state and FIFO pop decision. In WRITE a new request is popped
    // on the same edge that retires the last byte, so bursts chain without a gap.
    always_comb begin
        state_d = state_q;
        pop_s   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!empty_s) begin
                    pop_s   = 1'b1;
                    state_d = ST_WRITE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WRITE: begin
                if (accept_s && last_s) begin
                    if (!empty_s) begin
                        pop_s   = 1'b1;
                        state_d = ST_WRITE;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    state_d = ST_WRITE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM outputs: next byte/address for the RAM port and burst bookkeeping.
    // ram_* hold their value until the current byte is accepted.
    always_comb begin
        ram_we_d  = ram_we_q;
        ram_adr_d = ram_adr_q;
        ram_dat_d = ram_dat_q;
        cur_adr_d = cur_adr_q;
        cur_dat_d = cur_dat_q;
        rem_d     = rem_q;
        idx_d     = idx_q;
        if (pop_s) begin
            ram_we_d  = 1'b1;
            ram_adr_d = head_adr_s;
            ram_dat_d = first_byte(head_dat_s, head_cnt_s);
            cur_adr_d = head_adr_s;
            cur_dat_d = head_dat_s;
            rem_d     = head_cnt_s;
            idx_d     = 2'd0;
        end else if ((state_q == ST_WRITE) && accept_s && !last_s) begin
            idx_d     = idx_q + 2'd1;
            rem_d     = rem_q - 2'd1;
            // Decrement stays inside the page: only the low byte moves.
            ram_adr_d = {cur_adr_q[AW-1:8], cur_adr_q[7:0] - {6'd0, idx_q + 2'd1}};
            ram_dat_d = next_byte(cur_dat_q, idx_q + 2'd1);
        end else if ((state_q == ST_WRITE) && accept_s) begin
            ram_we_d  = 1'b0;
        end else begin
            ram_we_d  = ram_we_q;
        end
    end

    // Datapath registers for the RAM port and the request being serialized.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ram_we_q  <= 1'b0;
            ram_adr_q <= {AW{1'b0}};
            ram_dat_q <= 8'h00;
            cur_adr_q <= {AW{1'b0}};
            cur_dat_q <= 24'h000000;
            rem_q     <= 2'd0;
            idx_q     <= 2'd0;
        end else begin
            ram_we_q  <= ram_we_d;
            ram_adr_q <= ram_adr_d;
            ram_dat_q <= ram_dat_d;
            cur_adr_q <= cur_adr_d;
            cur_dat_q <= cur_dat_d;
            rem_q     <= rem_d;
            idx_q     <= idx_d;
        end
    end

`ifdef MEM_WR_OVF_EN
    logic ovf_q;

    // Sticky overflow: a request arrived while the FIFO was full.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ovf_q <= 1'b0;
        end else if (mem_w_enb_i && full_s) begin
            ovf_q <= 1'b1;
        end else begin
            ovf_q <= ovf_q;
        end
    end

    assign ovf_o = ovf_q;
`endif

endmodule

// File: tb/tb_mem_write_port.sv
module tb_mem_write_port;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enb;
    logic [1:0]  cnt;
    logic [15:0] adr;
    logic [23:0] dat;
    logic        stl;
    logic        ram_we;
    logic [15:0] ram_adr;
    logic [7:0]  ram_dat;
    logic        ram_rdy;
    logic        idle;
`ifdef MEM_WR_OVF_EN
    logic        ovf;
`endif

    mem_write_port #(
        .FIFO_DEPTH (2),
        .AW         (16)
    ) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .mem_w_enb_i (enb),
        .mem_w_cnt_i (cnt),
        .mem_w_adr_i (adr),
        .mem_w_dat_i (dat),
        .mem_stl_o   (stl),
        .ram_we_o    (ram_we),
        .ram_adr_o   (ram_adr),
        .ram_dat_o   (ram_dat),
        .ram_rdy_i   (ram_rdy),
        .idle_o      (idle)
`ifdef MEM_WR_OVF_EN
        ,
        .ovf_o       (ovf)
`endif
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // Byte monitor: records every accepted {adr, dat} and counts non-idle cycles.
    logic [23:0] acc_mem [0:63];
    int          acc_n   = 0;
    int          nidle_n = 0;

    always @(negedge clk) begin
        if (rst_n === 1'b1 && ram_we && ram_rdy && acc_n < 64) begin
            acc_mem[acc_n] = {ram_adr, ram_dat};
            acc_n = acc_n + 1;
        end
        if (rst_n === 1'b1 && !idle) begin
            nidle_n = nidle_n + 1;
        end
    end

    logic [23:0] exp_q [$];
    int          acc_rd  = 0;
    logic        saw_stl = 1'b0;
    int          n0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One-cycle request; an honouring requester waits while stalled.
    task automatic push(input logic [1:0] c, input logic [15:0] a, input logic [23:0] d,
                        input logic honour);
        int guard;
        guard = 0;
        if (honour) begin
            while (stl && guard < 50) begin
                tick();
                guard++;
            end
            if (guard > 0) saw_stl = 1'b1;
            chk("stall_bound", {31'd0, guard < 50}, 32'd1);
        end
        enb = 1'b1;
        cnt = c;
        adr = a;
        dat = d;
        tick();
        enb = 1'b0;
    endtask

    // Wait for idle, then compare accepted bytes against the expected list.
    task automatic drain(input string tag);
        int g;
        int k;
        logic [23:0] e;
        g = 0;
        while (!idle && g < 200) begin
            tick();
            g++;
        end
        chk({tag, "_idle"}, {31'd0, idle}, 32'd1);
        chk({tag, "_nbytes"}, acc_n - acc_rd, exp_q.size());
        k = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (acc_rd < acc_n) begin
                chk($sformatf("%s_b%0d", tag, k), {8'd0, acc_mem[acc_rd]}, {8'd0, e});
            end else begin
                chk($sformatf("%s_b%0d_missing", tag, k), 32'hFFFF_FFFF, {8'd0, e});
            end
            acc_rd++;
            k++;
        end
        acc_rd = acc_n;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, expected finish before 200000");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n   = 1'b0;
        enb     = 1'b0;
        cnt     = 2'd0;
        adr     = 16'h0000;
        dat     = 24'h000000;
        ram_rdy = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_we",   {31'd0, ram_we}, 32'd0);
        chk("rst_adr",  {16'd0, ram_adr}, 32'd0);
        chk("rst_dat",  {24'd0, ram_dat}, 32'd0);
        chk("rst_stl",  {31'd0, stl}, 32'd0);
        chk("rst_idle", {31'd0, idle}, 32'd1);
`ifdef MEM_WR_OVF_EN
        chk("rst_ovf",  {31'd0, ovf}, 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("post_rst_idle", {31'd0, idle}, 32'd1);

        // 1: single byte, cycle-accurate latency
        n0  = nidle_n;
        enb = 1'b1;
        cnt = 2'd0;
        adr = 16'h2000;
        dat = 24'h0000A5;
        tick();
        enb = 1'b0;
        chk("t1_we_lat", {31'd0, ram_we}, 32'd0);
        chk("t1_stl",    {31'd0, stl}, 32'd1);
        tick();
        chk("t1_we",     {31'd0, ram_we}, 32'd1);
        chk("t1_adr",    {16'd0, ram_adr}, 32'h2000);
        chk("t1_dat",    {24'd0, ram_dat}, 32'hA5);
        chk("t1_stl_lo", {31'd0, stl}, 32'd0);
        tick();
        chk("t1_we_off", {31'd0, ram_we}, 32'd0);
        chk("t1_idle",   {31'd0, idle}, 32'd1);
        exp_q.push_back(24'h2000A5);
        drain("t1");
        chk("t1_span", nidle_n - n0, 32'd2);

        // 2: three bytes, descending order, consecutive cycles
        n0 = nidle_n;
        push(2'd2, 16'h01FD, 24'h30C012, 1'b1);
        exp_q.push_back(24'h01FDC0);
        exp_q.push_back(24'h01FC12);
        exp_q.push_back(24'h01FB30);
        drain("t2");
        chk("t2_span", nidle_n - n0, 32'd4);

        // 3: two bytes with page wrap
        n0 = nidle_n;
        push(2'd1, 16'h0100, 24'h001234, 1'b1);
        exp_q.push_back(24'h010012);
        exp_q.push_back(24'h01FF34);
        drain("t3");
        chk("t3_span", nidle_n - n0, 32'd3);

        // 4: RAM not ready for 3 cycles mid-burst
        n0 = nidle_n;
        push(2'd2, 16'h3010, 24'hAABBCC, 1'b1);
        tick();
        chk("t4_first_adr", {16'd0, ram_adr}, 32'h3010);
        tick();
        ram_rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("t4_hold_we%0d", i),  {31'd0, ram_we}, 32'd1);
            chk($sformatf("t4_hold_adr%0d", i), {16'd0, ram_adr}, 32'h300F);
            chk($sformatf("t4_hold_dat%0d", i), {24'd0, ram_dat}, 32'hCC);
        end
        ram_rdy = 1'b1;
        exp_q.push_back(24'h3010BB);
        exp_q.push_back(24'h300FCC);
        exp_q.push_back(24'h300EAA);
        drain("t4");
        chk("t4_span", nidle_n - n0, 32'd7);

        // 5: back-to-back requests from a requester honouring the stall
        n0      = nidle_n;
        saw_stl = 1'b0;
        push(2'd1, 16'h4000, 24'h001122, 1'b1);
        push(2'd1, 16'h5005, 24'h007788, 1'b1);
        push(2'd2, 16'h6002, 24'h998877, 1'b1);
        chk("t5_saw_stl", {31'd0, saw_stl}, 32'd1);
        exp_q.push_back(24'h400011);
        exp_q.push_back(24'h40FF22);
        exp_q.push_back(24'h500577);
        exp_q.push_back(24'h500488);
        exp_q.push_back(24'h600288);
        exp_q.push_back(24'h600177);
        exp_q.push_back(24'h600099);
        drain("t5");
        chk("t5_span", nidle_n - n0, 32'd8);

        // 6: push while full is dropped (and flagged when enabled)
        ram_rdy = 1'b0;
        push(2'd0, 16'h7000, 24'h0000D1, 1'b0);
        push(2'd0, 16'h7001, 24'h0000E2, 1'b0);
        push(2'd0, 16'h7002, 24'h0000F3, 1'b0);
`ifdef MEM_WR_OVF_EN
        chk("t6_ovf_before", {31'd0, ovf}, 32'd0);
`endif
        push(2'd0, 16'h7003, 24'h000004, 1'b0);
        chk("t6_stl", {31'd0, stl}, 32'd1);
`ifdef MEM_WR_OVF_EN
        chk("t6_ovf_set", {31'd0, ovf}, 32'd1);
`endif
        tick();
        tick();
        chk("t6_hold_adr", {16'd0, ram_adr}, 32'h7000);
        chk("t6_hold_dat", {24'd0, ram_dat}, 32'hD1);
        ram_rdy = 1'b1;
        exp_q.push_back(24'h7000D1);
        exp_q.push_back(24'h7001E2);
        exp_q.push_back(24'h7002F3);
        drain("t6");
`ifdef MEM_WR_OVF_EN
        chk("t6_ovf_sticky", {31'd0, ovf}, 32'd1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
